// File: rtl/fp_vec_pkg.sv
// fp_vec_pkg: shared FSM state type and default operand-pair table for fp_vector_streamer
// Contents: state_t (IDLE/FETCH/SEND/FINISH), vec_word(idx) -> {op_a, op_b}, zero past the table
package fp_vec_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, SEND, FINISH} state_t;
  localparam int VEC_WIDTH = 64;
  function automatic logic [VEC_WIDTH-1:0] vec_word(input logic [31:0] idx);
    case (idx)
      32'd0:   return 64'h3f800000_40000000;
      32'd1:   return 64'hbf800000_3f800000;
      32'd2:   return 64'hc2de8000_45155e00;
      32'd3:   return 64'h6b64b235_6ac49214;
      32'd4:   return 64'h2ac49214_6ac49214;
      32'd5:   return 64'hbfc66666_3fc7ae14;
      32'd6:   return 64'hc565ee8b_4565ee8a;
      32'd7:   return 64'h447a4efa_c47a1ccd;
      32'd8:   return 64'h00000000_00000000;
      32'd9:   return 64'h00000000_40a00000;
      32'd10:  return 64'h38108900_bb908900;
      default: return '0;
    endcase
  endfunction
endpackage

// File: rtl/fp_vec_rom.sv
// fp_vec_rom: constant operand-pair ROM with registered read, contents from fp_vec_pkg
// Ports: clk, reset (sync, active-low, clears data_o), en_i (load read register),
//        addr_i (table index), data_o (registered word; addresses >= DEPTH read as zero)
module fp_vec_rom
  import fp_vec_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 11,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [AW-1:0]    addr_i,
  output logic [WIDTH-1:0] data_o
);
  always_ff @(posedge clk)
    if (!reset) data_o <= '0;
    else if (en_i) data_o <= (32'(addr_i) < DEPTH) ? WIDTH'(vec_word(32'(addr_i))) : '0;
endmodule

// File: rtl/fp_vector_streamer.sv
// fp_vector_streamer: streams the operand-pair table over valid/ready, single pass or looping
// Ports: clk, reset (sync, active-low); start/loop/stop commands; out_valid/out_ready handshake;
//        op_a/op_b/index presented pair; busy (not IDLE); done (one-cycle end-of-pass pulse);
//        pass_cnt (completed passes since start, wrapping)
module fp_vector_streamer
  import fp_vec_pkg::*;
#(
  parameter int OP_WIDTH   = 32,
  parameter int DEPTH      = 11,
  parameter int ADDR_WIDTH = 4,
  parameter int PASS_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  loop,
  input  logic                  stop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OP_WIDTH-1:0]   op_a,
  output logic [OP_WIDTH-1:0]   op_b,
  output logic [ADDR_WIDTH-1:0] index,
  output logic                  busy,
  output logic                  done,
  output logic [PASS_WIDTH-1:0] pass_cnt
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  state_t                  state_q, state_d;
  logic                    loop_q, loop_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d, index_q, index_d;
  logic [PASS_WIDTH-1:0]   pass_q, pass_d;
  logic                    go, hs, last;
  logic [2*OP_WIDTH-1:0]   pair;
  // the ROM read register is the op_a/op_b output register; it loads during FETCH
  fp_vec_rom #(.WIDTH(2*OP_WIDTH), .DEPTH(DEPTH), .AW(ADDR_WIDTH)) u_rom (
    .clk    (clk),
    .reset  (reset),
    .en_i   (state_q == FETCH),
    .addr_i (rd_addr_q),
    .data_o (pair)
  );
  always_ff @(posedge clk)
    if (!reset) begin
      state_q   <= IDLE;
      loop_q    <= 1'b0;
      rd_addr_q <= '0;
      index_q   <= '0;
      pass_q    <= '0;
    end else begin
      state_q   <= state_d;
      loop_q    <= loop_d;
      rd_addr_q <= rd_addr_d;
      index_q   <= index_d;
      pass_q    <= pass_d;
    end
  // stop beats both a pending start and a simultaneous handshake
  always_comb begin
    go        = state_q == IDLE && start && !stop;
    hs        = state_q == SEND && out_ready && !stop;
    last      = index_q == LAST;
    state_d   = stop               ? IDLE :
                state_q == IDLE    ? (start ? FETCH : IDLE) :
                state_q == FETCH   ? SEND :
                state_q == SEND    ? (!out_ready ? SEND : (!last || loop_q) ? FETCH : FINISH) :
                IDLE;
    loop_d    = go ? loop : loop_q;
    rd_addr_d = go ? '0 : hs ? (last ? '0 : rd_addr_q + ADDR_WIDTH'(1)) : rd_addr_q;
    index_d   = state_q == FETCH ? rd_addr_q : index_q;
    pass_d    = go ? '0 : (hs && last) ? pass_q + PASS_WIDTH'(1) : pass_q;
  end
  always_comb begin
    out_valid = state_q == SEND;
    busy      = state_q != IDLE;
    done      = state_q == FINISH;
    op_a      = pair[2*OP_WIDTH-1:OP_WIDTH];
    op_b      = pair[OP_WIDTH-1:0];
    index     = index_q;
    pass_cnt  = pass_q;
  end
endmodule

// File: tb/tb_fp_vector_streamer.sv
// tb_fp_vector_streamer: directed table-driven bench for fp_vector_streamer
module tb_fp_vector_streamer;
  typedef struct {
    logic [3:0]  idx;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;
  logic        clk = 1'b0;
  logic        reset, start, loop, stop, out_ready;
  logic        out_valid, busy, done;
  logic [31:0] op_a, op_b;
  logic [3:0]  index;
  logic [7:0]  pass_cnt;
  int          checks = 0;
  int          errors = 0;
  vec_t        tbl [11];
  fp_vector_streamer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .loop      (loop),
    .stop      (stop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .index     (index),
    .busy      (busy),
    .done      (done),
    .pass_cnt  (pass_cnt)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk_pair(input string nm, input int i);
    chk({nm, " valid"}, 64'(out_valid), 64'd1);
    chk({nm, " index"}, 64'(index), 64'(tbl[i].idx));
    chk({nm, " op_a"}, 64'(op_a), 64'(tbl[i].a));
    chk({nm, " op_b"}, 64'(op_b), 64'(tbl[i].b));
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, " valid"}, 64'(out_valid), 64'd0);
    chk({nm, " op_a"}, 64'(op_a), 64'd0);
    chk({nm, " op_b"}, 64'(op_b), 64'd0);
    chk({nm, " index"}, 64'(index), 64'd0);
    chk({nm, " busy"}, 64'(busy), 64'd0);
    chk({nm, " done"}, 64'(done), 64'd0);
    chk({nm, " pass_cnt"}, 64'(pass_cnt), 64'd0);
  endtask
  task automatic begin_stream(input logic lp);
    start = 1'b1;
    loop  = lp;
    step();
    start = 1'b0;
    step();
  endtask
  initial begin
    int   wrap;
    int   done_seen;
    logic [3:0] prev;
    tbl[0]  = '{4'd0,  32'h3f800000, 32'h40000000};
    tbl[1]  = '{4'd1,  32'hbf800000, 32'h3f800000};
    tbl[2]  = '{4'd2,  32'hc2de8000, 32'h45155e00};
    tbl[3]  = '{4'd3,  32'h6b64b235, 32'h6ac49214};
    tbl[4]  = '{4'd4,  32'h2ac49214, 32'h6ac49214};
    tbl[5]  = '{4'd5,  32'hbfc66666, 32'h3fc7ae14};
    tbl[6]  = '{4'd6,  32'hc565ee8b, 32'h4565ee8a};
    tbl[7]  = '{4'd7,  32'h447a4efa, 32'hc47a1ccd};
    tbl[8]  = '{4'd8,  32'h00000000, 32'h00000000};
    tbl[9]  = '{4'd9,  32'h00000000, 32'h40a00000};
    tbl[10] = '{4'd10, 32'h38108900, 32'hbb908900};
    reset = 1'b0; start = 1'b1; loop = 1'b0; stop = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    chk_zero("reset");
    reset = 1'b1;
    start = 1'b0;
    step();
    chk("idle busy", 64'(busy), 64'd0);
    begin_stream(1'b0);
    for (int i = 0; i < 11; i++) begin
      chk_pair("single", i);
      step();
      if (i < 10) begin
        chk("fetch gap valid", 64'(out_valid), 64'd0);
        step();
      end
    end
    chk("finish done", 64'(done), 64'd1);
    chk("finish pass_cnt", 64'(pass_cnt), 64'd1);
    step();
    chk("after done", 64'(done), 64'd0);
    chk("after busy", 64'(busy), 64'd0);
    chk("after pass_cnt", 64'(pass_cnt), 64'd1);
    begin_stream(1'b0);
    repeat (5) step();
    out_ready = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      chk_pair("stall", 3);
      step();
    end
    out_ready = 1'b1;
    chk_pair("stall end", 3);
    step();
    step();
    chk_pair("resume", 4);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop busy", 64'(busy), 64'd0);
    wrap = 0;
    done_seen = 0;
    prev = '0;
    start = 1'b1;
    loop  = 1'b1;
    for (int t = 1; t <= 50; t++) begin
      step();
      start = 1'b0;
      if (done) done_seen++;
      if (out_valid) begin
        if (index == 4'd0 && prev == 4'd10) wrap = 1;
        prev = index;
      end
      if (t == 22 || t == 44) chk("loop pass_cnt before", 64'(pass_cnt), 64'(t / 22 - 1));
      if (t == 23 || t == 45) chk("loop pass_cnt after", 64'(pass_cnt), 64'(t / 22));
    end
    chk("loop wrap seen", 64'(wrap), 64'd1);
    chk("loop no done", 64'(done_seen), 64'd0);
    chk("loop busy", 64'(busy), 64'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    begin_stream(1'b0);
    repeat (12) step();
    chk_pair("pre-stop", 6);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop valid", 64'(out_valid), 64'd0);
    chk("stop busy2", 64'(busy), 64'd0);
    chk("stop pass_cnt", 64'(pass_cnt), 64'd0);
    begin_stream(1'b0);
    chk_pair("restart", 0);
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    chk_pair("start ignored", 1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk_zero("midstream reset");
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    chk("start+stop idle", 64'(busy), 64'd0);
    step();
    chk("start+stop still idle", 64'(busy), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
